csr_status_unit: RTL and testbench
==================================

# csr_status_unit

Machine-mode CSR responder for the CPU pipeline. It services the CSR instructions (csrrw/csrrs/csrrc and immediate forms) that the software tests issue, holds the `tohost` status register that the C-test bench polls, and maintains the 64-bit cycle and instret counters. It sits beside the execute/writeback stage: the pipeline presents a decoded CSR access and receives the old CSR value on the same cycle, and the write commits at the next clock edge.

## Interface
Parameters:
- `HART_ID`, 32'd0, value returned by `mhartid` (0xF14).
- `TOHOST_ADDR`, 12'h51E, address of the `tohost` status CSR.

Ports:
- `clk` input 1: sole clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `csr_en` input 1: a CSR instruction is valid this cycle.
- `csr_op` input 2: 01 = RW, 10 = RS, 11 = RC, 00 = no-op (treated as a read).
- `csr_addr` input 12: CSR address.
- `csr_wdata` input 32: source operand, either rs1 or zero-extended uimm, muxed upstream.
- `csr_src_zero` input 1: the source is x0 or uimm = 0. RS/RC then perform no write.
- `stall` input 1: pipeline stall. Suppresses all commits, including `instret` increments.
- `retire` input 1: one instruction retired this cycle.
- `csr_rdata` output 32: old value of the addressed CSR (combinational).
- `csr_illegal` output 1: the current access is illegal (combinational).
- `tohost` output 32: current `tohost` register.
- `test_done` output 1: sticky; set after the first nonzero write to `tohost`.
- `test_pass` output 1: sticky; the first nonzero `tohost` write was 32'd1.

## Operation
Address map:
- `TOHOST_ADDR`: read/write.
- 0xC00 / 0xC80: `cycle` / `cycleh`, read-only.
- 0xC02 / 0xC82: `instret` / `instreth`, read-only.
- 0xF14: `mhartid`, read-only.

Write value by `csr_op`:
- RW: `wdata`.
- RS: `old | wdata`.
- RC: `old & ~wdata`.

A write is attempted when `csr_en` is high and either `csr_op` = RW, or `csr_op` is RS/RC with `csr_src_zero` = 0.

Illegal accesses:
- `csr_illegal` = `csr_en` & (unmapped address | attempted write to a read-only CSR).
- An illegal access commits nothing.
- `csr_rdata` is 0 for an unmapped address.

`tohost` register:
- Every committed write updates `tohost`.
- If `test_done` is 0 and the committed value is nonzero: `test_done` <= 1, and `test_pass` <= (value == 32'd1).
- Once `test_done` is set, later writes change `tohost` only. `test_done` and `test_pass` hold until `rst`.
- Writing 0 never sets `test_done`.

Counters (64-bit):
- `cycle` increments every non-reset cycle, regardless of `stall`.
- `instret` increments when `retire` & !`stall`.
- Both wrap from 2^64−1 to 0.
- Low and high halves are read from the same registered value, so there is no carry tearing within a cycle.

## Timing
- Reset values: `tohost` = 0, `test_done` = 0, `test_pass` = 0, `cycle` = 0, `instret` = 0.
- `csr_rdata` and `csr_illegal` depend only on the current inputs and registered state.
- On the first cycle after `rst` deasserts, `cycle` reads 0. It reads N after N further edges.
- Read latency is 0: `csr_rdata` reflects state before the edge.
- Write latency is 1: the new value is visible on the cycle after commit.
- Flag latency: `test_done`/`test_pass` rise on the edge that commits the first nonzero write, and are visible the next cycle.
- Commit condition: `csr_en` & !`stall` & !`csr_illegal` at the rising edge.
  - A stalled access may be held for many cycles.
  - It commits exactly once, on the first unstalled edge.
- Simultaneous events: read-only counters cannot be written, so counter increments never conflict with writes.
- `rst` mid-access: `rst` wins and the pending write is discarded.

## Structure
- Package `csr_pkg`:
  - CSR address localparams (`CSR_CYCLE`, `CSR_CYCLEH`, `CSR_INSTRET`, `CSR_INSTRETH`, `CSR_MHARTID`).
  - `csr_op` encodings (`CSR_NOP`, `CSR_RW`, `CSR_RS`, `CSR_RC`).
  - `TOHOST_ADDR` default.
- Sub-module `counter64`: 64-bit counter with synchronous reset and increment enable. It is instantiated twice, once for `cycle` and once for `instret`.
- Top level: address decode, read mux, write-value ALU, `tohost` register and sticky flags.

## Test plan
- **Reset.** Hold `rst` for 10 cycles, then release. Required: all outputs 0; read 0xC00 → 0 in the first cycle; after 5 more cycles, 0xC00 reads 5.
- **Pass path.** RW `TOHOST_ADDR` with 32'd1. Required: next cycle `tohost` = 1, `test_done` = 1, `test_pass` = 1. A later RW with 32'd7 gives `tohost` = 7 while `test_pass` stays 1.
- **Fail path.**
  - RW 0, then RW 32'd3. Required: after the 0 write, `test_done` stays 0. After the 3 write, `test_done` = 1 and `test_pass` = 0.
  - Then RS with 32'h4. Required: `tohost` = 7.
- **Set/clear semantics.**
  - `tohost` = 32'hF0, then RC with wdata 32'h30. Required: `tohost` = 32'hC0; `csr_rdata` during the access = 32'hF0.
  - RS with `csr_src_zero` = 1. Required: no change.
- **Illegal and stall.**
  - RW to 0xC00. Required: `csr_illegal` = 1 and `cycle` is unaffected.
  - Read 0x123. Required: `csr_illegal` = 1, `csr_rdata` = 0.
  - Hold RW `tohost` with 32'd1 under `stall` for 4 cycles. Required: no commit until `stall` falls, then exactly one commit.
- **Counter wrap and instret.**
  - Force `cycle` to 64'hFFFF_FFFF_FFFF_FFFE. Required: reads …FFFF, then 0 on the following edges; `cycleh` goes from 32'hFFFF_FFFF to 0 on the same edge.
  - Apply 3 `retire` pulses, one of them with `stall` = 1. Required: `instret` = 2.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: CSR address map, access-op encodings and write-value helper for csr_status_unit.
package csr_pkg;

    localparam logic [11:0] CSR_CYCLE           = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH          = 12'hC80;
    localparam logic [11:0] CSR_INSTRET         = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH        = 12'hC82;
    localparam logic [11:0] CSR_MHARTID         = 12'hF14;
    localparam logic [11:0] TOHOST_ADDR_DEFAULT = 12'h51E;

    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_alu(input csr_op_e op, input logic [31:0] old, input logic [31:0] wdata);
        return op == CSR_RS ? old | wdata : op == CSR_RC ? old & ~wdata : wdata;
    endfunction

endpackage

// File: rtl/counter64.sv
// counter64: 64-bit free-running counter with synchronous reset and increment enable.
module counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (rst) count <= 64'd0;
        else if (inc) count <= count + 64'd1;
    end

endmodule

// File: rtl/csr_status_unit.sv
// csr_status_unit: machine-mode CSR responder with tohost status register,
// sticky pass/done flags and 64-bit cycle/instret counters.
module csr_status_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [11:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_src_zero,
    input  logic        stall,
    input  logic        retire,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] tohost,
    output logic        test_done,
    output logic        test_pass
);

    logic [63:0] cycle;
    logic [63:0] instret;
    logic        is_tohost;
    logic        is_ro;
    logic        wr_try;
    logic        commit;
    logic [31:0] wval;

    counter64 u_cycle (.clk(clk), .rst(rst), .inc(1'b1), .count(cycle));
    counter64 u_instret (.clk(clk), .rst(rst), .inc(retire & ~stall), .count(instret));

    always_comb begin
        is_tohost   = csr_addr == TOHOST_ADDR;
        is_ro       = csr_addr inside {CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH, CSR_MHARTID};
        // RS/RC with a zero source are pure reads, so they are legal on read-only CSRs
        wr_try      = csr_en & (csr_op == CSR_RW | (csr_op != CSR_NOP & ~csr_src_zero));
        csr_illegal = csr_en & (~(is_tohost | is_ro) | (wr_try & is_ro));
        csr_rdata   = is_tohost                ? tohost :
                      csr_addr == CSR_CYCLE    ? cycle[31:0] :
                      csr_addr == CSR_CYCLEH   ? cycle[63:32] :
                      csr_addr == CSR_INSTRET  ? instret[31:0] :
                      csr_addr == CSR_INSTRETH ? instret[63:32] :
                      csr_addr == CSR_MHARTID  ? HART_ID : 32'd0;
        wval        = csr_alu(csr_op_e'(csr_op), tohost, csr_wdata);
        commit      = wr_try & is_tohost & ~stall & ~csr_illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost    <= 32'd0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
        end else if (commit) begin
            tohost <= wval;
            if (!test_done && wval != 32'd0) begin
                test_done <= 1'b1;
                test_pass <= wval == 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_csr_status_unit.sv
// tb_csr_status_unit: table-driven check of csr_status_unit with a post-edge scoreboard
// plus hand sequences for stall hold, instret gating and counter wrap.
module tb_csr_status_unit;

    localparam logic [31:0] HID = 32'h0000_00A5;
    localparam logic [11:0] TH  = 12'h51E;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_en = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = 32'd0;
    logic        csr_src_zero = 1'b0;
    logic        stall = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] tohost;
    logic        test_done;
    logic        test_pass;

    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] cyc_model;

    csr_status_unit #(.HART_ID(HID), .TOHOST_ADDR(TH)) dut (
        .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero), .stall(stall), .retire(retire),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .tohost(tohost),
        .test_done(test_done), .test_pass(test_pass)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_model <= rst ? 64'd0 : cyc_model + 64'd1;

    typedef struct {
        logic        do_rst;
        logic        en;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        sz;
        logic        stl;
        logic        rd_cyc;
        logic [31:0] rd;
        logic        ill;
        logic [31:0] th;
        logic        done;
        logic        pass;
    } vec_t;

    typedef struct {
        logic [31:0] th;
        logic        done;
        logic        pass;
    } post_t;

    vec_t  vecs[18];
    post_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic en, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic sz, input logic stl);
        csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wdata; csr_src_zero = sz; stall = stl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst   en    op     addr     wdata   sz    stl  rdcyc  rd     ill   th     done  pass
        vecs[0]  = '{1'b0, 1'b1, 2'b01, TH,      32'd1,  1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd1,  1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, TH,      32'd7,  1'b0, 1'b0, 1'b0, 32'd1,  1'b0, 32'd7,  1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 2'b01, TH,      32'd5,  1'b0, 1'b0, 1'b0, 32'd7,  1'b0, 32'd0,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, TH,      32'd0,  1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, TH,      32'd3,  1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd3,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, TH,      32'h4,  1'b0, 1'b0, 1'b0, 32'd3,  1'b0, 32'd7,  1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b01, TH,      32'hF0, 1'b0, 1'b0, 1'b0, 32'd7,  1'b0, 32'hF0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b11, TH,      32'h30, 1'b0, 1'b0, 1'b0, 32'hF0, 1'b0, 32'hC0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, TH,      32'hFF, 1'b1, 1'b0, 1'b0, 32'hC0, 1'b0, 32'hC0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b11, TH,      32'hFF, 1'b1, 1'b0, 1'b0, 32'hC0, 1'b0, 32'hC0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b01, 12'hC00, 32'd0,  1'b0, 1'b0, 1'b1, 32'd0,  1'b1, 32'hC0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 12'h123, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'hC0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'b01, 12'h123, 32'd9,  1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'hC0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'b00, 12'hF14, 32'd0,  1'b0, 1'b0, 1'b0, HID,    1'b0, 32'hC0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'b10, 12'hF14, 32'd0,  1'b1, 1'b0, 1'b0, HID,    1'b0, 32'hC0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 2'b10, 12'hF14, 32'd1,  1'b0, 1'b0, 1'b0, HID,    1'b1, 32'hC0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 2'b01, TH,      32'd1,  1'b0, 1'b1, 1'b0, 32'hC0, 1'b0, 32'hC0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 2'b01, TH,      32'd9,  1'b0, 1'b0, 1'b0, 32'hC0, 1'b0, 32'hC0, 1'b1, 1'b0};

        // reset and cycle counter start
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_tohost", 64'(tohost), 64'd0);
        chk("rst_done", 64'(test_done), 64'd0);
        chk("rst_pass", 64'(test_pass), 64'd0);
        chk("rst_illegal", 64'(csr_illegal), 64'd0);
        drive(1'b1, 2'b00, 12'hC00, 32'd0, 1'b0, 1'b0);
        #1;
        chk("cycle_first", 64'(csr_rdata), 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("cycle_after5", 64'(csr_rdata), 64'd5);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst = vecs[i].do_rst;
            drive(vecs[i].en, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].sz, vecs[i].stl);
            #1;
            chk($sformatf("v%0d_rdata", i), 64'(csr_rdata), vecs[i].rd_cyc ? 64'(cyc_model[31:0]) : 64'(vecs[i].rd));
            chk($sformatf("v%0d_illegal", i), 64'(csr_illegal), 64'(vecs[i].ill));
            sb.push_back('{vecs[i].th, vecs[i].done, vecs[i].pass});
            @(posedge clk);
            #1;
            begin
                post_t p;
                p = sb.pop_front();
                chk($sformatf("v%0d_tohost", i), 64'(tohost), 64'(p.th));
                chk($sformatf("v%0d_done", i), 64'(test_done), 64'(p.done));
                chk($sformatf("v%0d_pass", i), 64'(test_pass), 64'(p.pass));
            end
            if (i == 10) begin
                csr_op = 2'b00;
                #1;
                chk("cycle_after_illegal", 64'(csr_rdata), 64'(cyc_model[31:0]));
            end
        end
        rst = 1'b0;

        // stalled write held for four cycles commits exactly once
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 2'b00, 12'h000, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'b01, TH, 32'd1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_tohost", k), 64'(tohost), 64'd0);
            chk($sformatf("stall%0d_done", k), 64'(test_done), 64'd0);
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("unstall_tohost", 64'(tohost), 64'd1);
        chk("unstall_done", 64'(test_done), 64'd1);
        chk("unstall_pass", 64'(test_pass), 64'd1);
        @(negedge clk);
        drive(1'b1, 2'b10, TH, 32'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("after_one_commit_rs", 64'(tohost), 64'd3);

        // instret gated by stall
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 2'b00, 12'h000, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        retire = 1'b1;
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        retire = 1'b0;
        drive(1'b1, 2'b00, 12'hC02, 32'd0, 1'b0, 1'b0);
        #1;
        chk("instret", 64'(csr_rdata), 64'd2);
        csr_addr = 12'hC82;
        #1;
        chk("instreth", 64'(csr_rdata), 64'd0);

        // cycle wrap, both halves from the same registered value
        @(negedge clk);
        force dut.u_cycle.count = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.u_cycle.count;
        csr_addr = 12'hC00;
        #1;
        chk("wrap_lo0", 64'(csr_rdata), 64'hFFFF_FFFE);
        @(posedge clk);
        #1;
        chk("wrap_lo1", 64'(csr_rdata), 64'hFFFF_FFFF);
        csr_addr = 12'hC80;
        #1;
        chk("wrap_hi1", 64'(csr_rdata), 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("wrap_hi2", 64'(csr_rdata), 64'd0);
        csr_addr = 12'hC00;
        #1;
        chk("wrap_lo2", 64'(csr_rdata), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
